// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load-store unit: FSM states and the
// default widths used by the pipeline registers around it.
package lsu_pkg;

   localparam int LSU_DATA_W   = 16;
   localparam int LSU_ADDR_W   = 16;
   localparam int LSU_RD_W     = 3;
   localparam int LSU_SQ_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_WAIT  = 2'd1,
      DRAIN_WAIT = 2'd2
   } lsu_state_e;

endpackage

// File: rtl/lsu_sq_fifo.sv
// Store queue circular buffer with a combinational youngest-match search port
// used for store-to-load forwarding.
module lsu_sq_fifo
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   input  logic [ADDR_W-1:0] srch_addr,
   output logic              srch_hit,
   output logic [DATA_W-1:0] srch_data
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  scan_idx;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  vld_q;

   assign wr_idx    = wr_ptr[IDX_W-1:0];
   assign rd_idx    = rd_ptr[IDX_W-1:0];
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);
   assign head_addr = addr_q[rd_idx];
   assign head_data = data_q[rd_idx];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         vld_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (push && !full) begin
            addr_q[wr_idx] <= push_addr;
            data_q[wr_idx] <= push_data;
            vld_q[wr_idx]  <= 1'b1;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            vld_q[rd_idx] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
      end
   end

   // Walk from tail-1 back toward head; the first valid match is the youngest.
   always_comb begin
      srch_hit  = 1'b0;
      srch_data = '0;
      scan_idx  = '0;
      for (int i = 1; i <= DEPTH; i++) begin
         scan_idx = wr_idx - IDX_W'(i);
         if (!srch_hit && vld_q[scan_idx] && (addr_q[scan_idx] == srch_addr)) begin
            srch_hit  = 1'b1;
            srch_data = data_q[scan_idx];
         end
      end
   end

endmodule

// File: rtl/lsu_store_queue.sv
// Memory-stage load-store unit: core request/response, store queue with
// forwarding, and a single-outstanding memory port that drains stores when idle.
module lsu_store_queue
   import lsu_pkg::*;
#(
   parameter int DATA_W   = LSU_DATA_W,
   parameter int ADDR_W   = LSU_ADDR_W,
   parameter int RD_W     = LSU_RD_W,
   parameter int SQ_DEPTH = LSU_SQ_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [RD_W-1:0]   req_rd,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [RD_W-1:0]   rsp_rd,
   output logic              sq_empty,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output lsu_state_e        dbg_state
);

   // Handshakes: a core request transfers on a rising edge with req_valid && req_ready,
   // and req_ready depends only on registered state. mem_req holds address/data/we
   // stable until the edge where mem_ack is high, then drops the following cycle.
   lsu_state_e        state;
   logic              sq_full;
   logic              sq_fifo_empty;
   logic              accept;
   logic              push;
   logic              pop;
   logic              ld_acc;
   logic              srch_hit;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [DATA_W-1:0] srch_data;
   logic [RD_W-1:0]   ld_rd;

   assign req_ready = (state == IDLE) && !sq_full;
   assign accept    = req_valid && req_ready;
   assign push      = accept && req_is_store;
   assign ld_acc    = accept && !req_is_store;
   assign pop       = (state == DRAIN_WAIT) && mem_ack;
   assign sq_empty  = sq_fifo_empty && (state != DRAIN_WAIT);
   assign dbg_state = state;

   lsu_sq_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (SQ_DEPTH)
   ) u_sq (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_addr (req_addr),
      .push_data (req_wdata),
      .pop       (pop),
      .full      (sq_full),
      .empty     (sq_fifo_empty),
      .head_addr (head_addr),
      .head_data (head_data),
      .srch_addr (req_addr),
      .srch_hit  (srch_hit),
      .srch_data (srch_data)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_rd    <= '0;
         ld_rd     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (ld_acc) begin
                  if (srch_hit) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= srch_data;
                     rsp_rd    <= req_rd;
                  end else begin
                     state     <= LOAD_WAIT;
                     ld_rd     <= req_rd;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_addr  <= req_addr;
                     mem_wdata <= '0;
                  end
               end else if (!accept && !sq_fifo_empty) begin
                  // Drains only use cycles the core left empty.
                  state     <= DRAIN_WAIT;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= head_addr;
                  mem_wdata <= head_data;
               end
            end
            LOAD_WAIT: begin
               if (mem_ack) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b1;
                  rsp_data  <= mem_rdata;
                  rsp_rd    <= ld_rd;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
               end
            end
            DRAIN_WAIT: begin
               if (mem_ack) begin
                  state     <= IDLE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_store_queue.sv
// Self-checking bench for lsu_store_queue: architectural memory model, expected
// response/write queues, and a memory responder with programmable ack delay.
module tb_lsu_store_queue;
   import lsu_pkg::*;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [2:0]  req_rd;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_rd;
   logic        sq_empty;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   lsu_state_e  dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int ack_cyc = -10;
   int ack_delay = 2;
   int wait_cnt = 0;
   int occ = 0;
   int ready_cyc = 0;
   logic first_ready;
   logic ack_we = 1'b0;
   logic miss_pending = 1'b0;
   logic prev_req = 1'b0;
   logic [15:0] last_load_addr = '0;
   logic        h_we;
   logic [15:0] h_addr;
   logic [15:0] h_data;

   logic [15:0] mem_arr [256];
   logic [15:0] ref_mem [256];
   logic [31:0] exp_wr_q[$];
   logic [18:0] exp_rsp_q[$];
   int          exp_rcyc_q[$];

   lsu_store_queue dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_store (req_is_store),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_rd       (rsp_rd),
      .sq_empty     (sq_empty),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: sim time limit reached, %0d miscompares so far", n_err);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // driver tasks: called and return at posedge+1
   task automatic send(input logic st, input logic [15:0] a, input logic [15:0] d,
                       input logic [2:0] rd);
      int  waitc;
      logic hit;
      req_valid    = 1'b1;
      req_is_store = st;
      req_addr     = a;
      req_wdata    = d;
      req_rd       = rd;
      waitc        = 0;
      @(negedge clock);
      first_ready = req_ready;
      while (!req_ready && waitc < 200) begin
         waitc++;
         @(negedge clock);
      end
      if (!req_ready) begin
         chk("req_ready_timeout", req_ready, 1);
         req_valid = 1'b0;
      end else begin
         ready_cyc = cyc;
         if (st) begin
            ref_mem[a[7:0]] = d;
            exp_wr_q.push_back({a, d});
         end else begin
            hit = 1'b0;
            foreach (exp_wr_q[k]) if (exp_wr_q[k][31:16] == a) hit = 1'b1;
            exp_rsp_q.push_back({rd, ref_mem[a[7:0]]});
            exp_rcyc_q.push_back(hit ? cyc + 1 : -1);
            last_load_addr = a;
            if (!hit) miss_pending = 1'b1;
         end
         @(posedge clock);
         if (st) occ++;
         #1;
      end
   endtask

   task automatic req_idle();
      req_valid = 1'b0;
   endtask

   task automatic wait_quiet(output int ecyc);
      int n;
      n = 0;
      @(negedge clock);
      while (!(sq_empty && !mem_req && exp_rsp_q.size() == 0) && n < 300) begin
         n++;
         @(negedge clock);
      end
      chk("quiet_timeout", sq_empty && !mem_req, 1);
      ecyc = cyc;
      @(posedge clock);
      #1;
   endtask

   // memory responder: ack arrives ack_delay cycles after mem_req first rises
   initial begin : mem_model
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clock);
         #1;
         if (reset && mem_ack && ack_we) occ--;
         mem_ack = 1'b0;
         if (reset && mem_req) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack  = 1'b1;
               ack_cyc  = cyc;
               ack_we   = mem_we;
               wait_cnt = 0;
               if (mem_we) begin
                  mem_arr[mem_addr[7:0]] = mem_wdata;
                  if (exp_wr_q.size() > 0) void'(exp_wr_q.pop_front());
               end else begin
                  mem_rdata = mem_arr[mem_addr[7:0]];
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // scoreboard: load responses
   initial begin : rsp_mon
      logic [18:0] e;
      int          ec;
      forever begin
         @(negedge clock);
         if (reset && rsp_valid) begin
            if (exp_rsp_q.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 0);
            end else begin
               e  = exp_rsp_q.pop_front();
               ec = exp_rcyc_q.pop_front();
               chk("rsp_data", rsp_data, e[15:0]);
               chk("rsp_rd", rsp_rd, e[18:16]);
               if (ec < 0) chk("rsp_miss_latency", cyc, ack_cyc + 1);
               else        chk("rsp_fwd_latency", cyc, ec);
            end
         end
      end
   end

   // scoreboard: memory-side requests, stability and occupancy flags
   initial begin : mem_mon
      forever begin
         @(negedge clock);
         if (!reset) begin
            prev_req = 1'b0;
         end else begin
            if (mem_req && !prev_req) begin
               if (miss_pending) begin
                  h_we = 1'b0; h_addr = last_load_addr; h_data = '0;
                  miss_pending = 1'b0;
               end else if (exp_wr_q.size() > 0) begin
                  h_we = 1'b1;
                  {h_addr, h_data} = exp_wr_q[0];
               end else begin
                  chk("mem_req_unexpected", mem_req, 0);
                  h_we = mem_we; h_addr = mem_addr; h_data = mem_wdata;
               end
            end
            if (mem_req) begin
               chk("mem_we", mem_we, h_we);
               chk("mem_addr", mem_addr, h_addr);
               if (h_we) chk("mem_wdata", mem_wdata, h_data);
            end
            if (!mem_req && prev_req) begin
               chk("mem_drop_latency", cyc, ack_cyc + 1);
               chk("mem_we_drop", mem_we, 0);
            end
            if (occ >= 4) chk("full_ready", req_ready, 0);
            if (occ > 0)  chk("sq_empty_busy", sq_empty, 0);
            else          chk("sq_empty_idle", sq_empty, 1);
            prev_req = mem_req;
         end
      end
   end

   initial begin : stim
      int ecyc;
      int n;
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 16'hC000 | 16'(i);
         ref_mem[i] = 16'hC000 | 16'(i);
      end
      mem_arr[8'h30] = 16'hBEEF;
      ref_mem[8'h30] = 16'hBEEF;
      reset = 1'b0;
      req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_rd", rsp_rd, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_sq_empty", sq_empty, 1);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      #2 reset = 1'b1;
      @(posedge clock); #1;

      // store then forwarded load
      send(1'b1, 16'h0010, 16'h00A5, 3'd0);
      send(1'b0, 16'h0010, 16'h0000, 3'd3);
      req_idle();
      @(negedge clock);
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_data", rsp_data, 16'h00A5);
      chk("t1_rsp_rd", rsp_rd, 3);
      chk("t1_no_mem_req", mem_req, 0);
      @(posedge clock); #1;
      wait_quiet(ecyc);

      // youngest match wins
      send(1'b1, 16'h0020, 16'h1111, 3'd0);
      send(1'b1, 16'h0020, 16'h2222, 3'd0);
      send(1'b0, 16'h0020, 16'h0000, 3'd5);
      req_idle();
      @(negedge clock);
      chk("t2_rsp_valid", rsp_valid, 1);
      chk("t2_rsp_data", rsp_data, 16'h2222);
      @(posedge clock); #1;
      wait_quiet(ecyc);

      // load miss with slow memory
      ack_delay = 3;
      send(1'b0, 16'h0030, 16'h0000, 3'd2);
      req_idle();
      n = 0;
      @(negedge clock);
      while (!rsp_valid && n < 20) begin
         chk("t3_req_held", mem_req, 1);
         chk("t3_we_read", mem_we, 0);
         n++;
         @(negedge clock);
      end
      chk("t3_latency", n, ack_delay + 1);
      chk("t3_rsp_data", rsp_data, 16'hBEEF);
      chk("t3_mem_req_low", mem_req, 0);
      @(posedge clock); #1;
      wait_quiet(ecyc);

      // fill the queue with the request held valid
      ack_delay = 2;
      for (int i = 0; i < 4; i++) send(1'b1, 16'h0040 + 16'(i), 16'($urandom_range(0, 65535)), 3'd0);
      send(1'b1, 16'h0044, 16'h4444, 3'd0);
      chk("t4_full_ready", first_ready, 0);
      chk("t4_fifth_accept", ready_cyc, ack_cyc + 1);
      req_idle();
      wait_quiet(ecyc);
      chk("t4_empty_after_ack", ecyc, ack_cyc + 1);
      chk("t4_writes_done", exp_wr_q.size(), 0);

      // reset during a drain
      ack_delay = 3;
      send(1'b1, 16'h0050, 16'h5A5A, 3'd0);
      send(1'b1, 16'h0051, 16'h6B6B, 3'd0);
      req_idle();
      n = 0;
      @(negedge clock);
      while (!mem_req && n < 50) begin
         n++;
         @(negedge clock);
      end
      chk("t5_drain_we", mem_we, 1);
      #2 reset = 1'b0;
      #1;
      chk("t5_mem_req_async", mem_req, 0);
      chk("t5_sq_empty", sq_empty, 1);
      chk("t5_state", 32'(dbg_state), 32'(IDLE));
      exp_wr_q.delete();
      exp_rsp_q.delete();
      exp_rcyc_q.delete();
      occ = 0;
      miss_pending = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem_arr[i];
      @(negedge clock);
      #2 reset = 1'b1;
      @(posedge clock); #1;
      send(1'b0, 16'h0050, 16'h0000, 3'd6);
      req_idle();
      @(negedge clock);
      chk("t5_load_misses", mem_req, 1);
      chk("t5_load_read", mem_we, 0);
      chk("t5_no_fwd", rsp_valid, 0);
      n = 0;
      while (!rsp_valid && n < 20) begin
         n++;
         @(negedge clock);
      end
      chk("t5_old_data", rsp_data, 16'hC050);
      @(posedge clock); #1;
      wait_quiet(ecyc);

      // pointer wrap: nine stores through four entries, with forwarded loads
      ack_delay = 1;
      for (int i = 0; i < 9; i++) begin
         send(1'b1, 16'h0060 + 16'(i), 16'($urandom_range(0, 65535)), 3'd0);
         if (i % 3 == 2) send(1'b0, 16'h0060 + 16'(i - 1), 16'h0000, 3'(i));
      end
      req_idle();
      wait_quiet(ecyc);
      chk("t6_writes_done", exp_wr_q.size(), 0);
      chk("t6_ready", req_ready, 1);

      // random mix over a small address window
      for (int i = 0; i < 40; i++) begin
         ack_delay = $urandom_range(1, 3);
         send(1'($urandom_range(0, 1)), 16'h0070 + 16'($urandom_range(0, 3)),
              16'($urandom_range(0, 65535)), 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 3) == 0) begin
            req_idle();
            repeat ($urandom_range(1, 4)) @(posedge clock);
            #1;
         end
      end
      req_idle();
      wait_quiet(ecyc);
      chk("end_wr_q", exp_wr_q.size(), 0);
      chk("end_rsp_q", exp_rsp_q.size(), 0);
      chk("end_sq_empty", sq_empty, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_store_queue.md
# lsu_store_queue

Parametrised load-store unit for the memory stage of the 16-bit pipeline. It replaces the bare memory-stage wiring with a request/response handshake toward the core and a single-outstanding request/ack handshake toward data memory. It adds a store queue with store-to-load forwarding, so accepted stores retire without waiting for memory. Stores drain to memory in the background whenever the unit is otherwise idle.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, word address width; memory is word-addressed and supports full-word accesses only
- RD_W, 3, destination register tag width
- SQ_DEPTH, 4, store queue entries; power of two, 2 or more

- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; forces reset state immediately
- req_valid  in  1  core request present
- req_ready  out  1  unit accepts the request this cycle
- req_is_store  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- req_rd  in  RD_W  load destination tag
- rsp_valid  out  1  one-cycle pulse carrying load result
- rsp_data  out  DATA_W  load data
- rsp_rd  out  RD_W  tag of the completing load
- sq_empty  out  1  store queue empty and no drain in flight; used as a fence
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write (drain), 0 = read (load miss)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  DATA_W  read data, valid with mem_ack

## Operation
- States: IDLE, LOAD_WAIT, DRAIN_WAIT.
- req_ready = (state == IDLE) && !sq_full. It is independent of req_is_store. It has no combinational path from req_valid.
- An accepted store is pushed at the queue tail and completes with no response.
- An accepted load searches all valid entries for a matching address.
  - Hit: forward the data of the youngest matching entry. Stay in IDLE.
  - Miss: latch the address and tag, then go to LOAD_WAIT.
- IDLE, no request accepted, queue non-empty: go to DRAIN_WAIT and issue the head entry as a write.
- Loads have priority over drains. Drains start only on cycles with no accepted request.
- Queue full with req_valid held: req_ready is 0, so a drain starts. There is no deadlock.
- LOAD_WAIT: mem_req=1, mem_we=0. On mem_ack: capture mem_rdata, pulse the response, return to IDLE.
- DRAIN_WAIT: mem_req=1, mem_we=1, with the head address and data. On mem_ack: pop the head, return to IDLE.
- A load must never see memory data older than a queued store to the same address. The forwarding search together with in-order draining guarantees this.
- Queue pointers are log2(SQ_DEPTH)+1 bits wide.
  - The extra MSB distinguishes full from empty.
  - Pointers wrap modulo 2*SQ_DEPTH.
- sq_empty = (count == 0) && (state != DRAIN_WAIT).

## Timing
- Reset values:
  - state IDLE, queue count 0, pointers 0.
  - rsp_valid 0, rsp_data 0, rsp_rd 0.
  - mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0.
  - sq_empty 1, req_ready 1.
- Forwarded load: rsp_valid rises in cycle N+1 after acceptance in cycle N.
- Missed load:
  - mem_req rises in cycle N+1.
  - With mem_ack in cycle M, rsp_valid pulses in cycle M+1.
  - mem_ack is never expected in the same cycle mem_req first rises.
- Drain: mem_req rises the cycle after the IDLE decision. The pop takes effect at the mem_ack edge, so the entry is free in the next cycle.
- mem_addr, mem_we and mem_wdata are registered. They stay stable while mem_req=1 and drop with mem_req the cycle after mem_ack.
- Back-to-back accepted stores are allowed at one per cycle.
- No push and pop happen in the same cycle: pops occur only in DRAIN_WAIT, and pushes only in IDLE.
- Reset asserted mid-transaction: queue contents are discarded, mem_req drops asynchronously, and any pending load response is lost. The memory side must tolerate an abandoned request.

## Structure
- Package lsu_pkg holds the state enum (IDLE, LOAD_WAIT, DRAIN_WAIT) and the default width constants shared with the pipeline registers.
- Sub-module lsu_sq_fifo holds the circular buffer.
  - Storage is address, data and a valid bit per entry.
  - Ports: push, pop, full, empty, head outputs.
  - Combinational search port: hit plus youngest-match data. Youngest is determined by scanning from tail-1 back toward head.
- The top level contains the FSM, the response registers and the memory-side registers.

## Test plan
- Reset, then store 0x00A5 to address 0x0010 and load 0x0010 with tag 3 the next cycle -> rsp_valid in the following cycle with rsp_data=0x00A5, rsp_rd=3, and no mem_req before the response.
- Stores 0x1111 then 0x2222 to address 0x0020, then load 0x0020 -> forwarded 0x2222 (youngest match).
- Load 0x0030 with empty queue, mem_ack 3 cycles later with rdata 0xBEEF -> mem_req/mem_we=0 stable throughout, rsp_valid=1 with 0xBEEF one cycle after ack.
- SQ_DEPTH=4, five consecutive stores held valid:
  - req_ready drops after the fourth store.
  - A drain of the oldest entry starts.
  - The fifth store is accepted the cycle after the ack.
  - Memory observes the writes in order, and sq_empty rises only after the last drain ack.
- Assert reset while in DRAIN_WAIT with 2 entries queued -> mem_req=0 immediately, sq_empty=1, and after release a load to a previously queued address misses to memory.
- Pointer wrap: push and drain 9 entries through SQ_DEPTH=4 -> correct FIFO order and correct full/empty flags across wrap.
